// File: rtl/pe_psum_accumulator_pkg.sv
// Shared constants, state encoding and helpers for the PE partial-sum accumulator.
package pe_psum_pkg;
    localparam int PSUM_W = 21;
    localparam int PROD_W = 16;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    function automatic logic signed [PSUM_W-1:0] sext_psum(input logic signed [PROD_W-1:0] p);
        return {{(PSUM_W - PROD_W){p[PROD_W-1]}}, p};
    endfunction

    // Out-of-range entry counts (0 or above DEPTH) fall back to the full scratchpad.
    function automatic logic [ADDR_W:0] clamp_num(input logic [ADDR_W:0] n);
        return ((n == '0) || (n > DEPTH_N)) ? DEPTH_N : n;
    endfunction
endpackage

// File: rtl/pe_psum_accumulator_if.sv
// Handshake bundle between the MAC array, upstream psum FIFO, local psum FIFO and the accumulator.
interface pe_psum_accumulator_if;
    import pe_psum_pkg::*;

    logic                     cfg_valid;
    logic                     cfg_ready;
    logic [ADDR_W:0]          cfg_num_psum;
    logic                     cfg_bypass_in;
    logic                     prod_valid;
    logic                     prod_ready;
    logic signed [PROD_W-1:0] prod_data;
    logic [ADDR_W-1:0]        prod_addr;
    logic                     prod_last;
    logic                     psum_in_valid;
    logic                     psum_in_ready;
    logic signed [PSUM_W-1:0] psum_in_data;
    logic                     psum_out_valid;
    logic                     psum_out_ready;
    logic signed [PSUM_W-1:0] psum_out_data;
    logic                     busy;
    logic                     err_addr;

    modport master (
        output cfg_valid, cfg_num_psum, cfg_bypass_in,
        output prod_valid, prod_data, prod_addr, prod_last,
        output psum_in_valid, psum_in_data, psum_out_ready,
        input  cfg_ready, prod_ready, psum_in_ready, psum_out_valid, psum_out_data, busy, err_addr
    );

    modport slave (
        input  cfg_valid, cfg_num_psum, cfg_bypass_in,
        input  prod_valid, prod_data, prod_addr, prod_last,
        input  psum_in_valid, psum_in_data, psum_out_ready,
        output cfg_ready, prod_ready, psum_in_ready, psum_out_valid, psum_out_data, busy, err_addr
    );
endinterface

// File: rtl/pe_psum_accumulator_spad.sv
// Psum scratchpad: DEPTH x PSUM_W entries with per-entry valid bits and one shared
// address serving both the accumulate read-modify-write and the drain read.
module pe_psum_spad
    import pe_psum_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        addr,
    input  logic signed [PSUM_W-1:0] add_val,
    output logic signed [PSUM_W-1:0] rd_val
);
    logic signed [PSUM_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]         vld_q, vld_d;
    logic signed [PSUM_W-1:0] wr_data;

    // Unwritten entries read as zero, so the first product to an entry needs no special path.
    assign rd_val  = vld_q[addr] ? mem_q[addr] : '0;
    assign wr_data = rd_val + add_val;

    always_comb begin
        vld_d = vld_q;
        if (clr) begin
            vld_d = '0;
        end else if (wr_en) begin
            vld_d[addr] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
    end
endmodule

// File: rtl/pe_psum_accumulator.sv
// Per-PE psum stage: accumulates MAC products per output channel, then drains each entry
// merged with the upstream PE's psum into the local psum FIFO.
module pe_psum_accumulator
    import pe_psum_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    pe_psum_accumulator_if.slave  io
);
    state_t            state_q, state_d;
    logic [ADDR_W:0]   num_q, num_d;
    logic              bypass_q, bypass_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              err_q, err_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              busy_q, busy_d;
    logic              prod_ready_q, prod_ready_d;

    logic                     drain, in_range, prod_fire, spad_wr, spad_clr;
    logic                     out_valid, out_fire, last_idx;
    logic [ADDR_W-1:0]        spad_addr;
    logic signed [PSUM_W-1:0] prod_ext, spad_rd, in_term, drain_sum;

    assign drain     = (state_q == DRAIN);
    assign in_range  = ({1'b0, io.prod_addr} < num_q);
    assign prod_fire = io.prod_valid & prod_ready_q;
    assign spad_wr   = prod_fire & in_range;
    assign spad_clr  = (state_q == IDLE) & io.cfg_valid;
    assign spad_addr = (state_q == ACCUM) ? io.prod_addr : idx_q;
    assign prod_ext  = sext_psum(io.prod_data);

    pe_psum_spad u_spad (
        .clock   (clock),
        .reset   (reset),
        .clr     (spad_clr),
        .wr_en   (spad_wr),
        .addr    (spad_addr),
        .add_val (prod_ext),
        .rd_val  (spad_rd)
    );

    // Drain merge is purely combinational so the FIFO sees no added latency.
    assign in_term   = bypass_q ? '0 : io.psum_in_data;
    assign drain_sum = spad_rd + in_term;
    assign out_valid = drain & (bypass_q | io.psum_in_valid);
    assign out_fire  = out_valid & io.psum_out_ready;
    assign last_idx  = ({1'b0, idx_q} == (num_q - 1'b1));

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        bypass_d = bypass_q;
        idx_d    = idx_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (io.cfg_valid) begin
                    state_d  = ACCUM;
                    num_d    = clamp_num(io.cfg_num_psum);
                    bypass_d = io.cfg_bypass_in;
                    idx_d    = '0;
                    err_d    = 1'b0;
                end
            end
            ACCUM: begin
                if (prod_fire) begin
                    if (!in_range) err_d = 1'b1;
                    if (io.prod_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    if (last_idx) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        cfg_ready_d  = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        prod_ready_d = (state_d == ACCUM);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            num_q        <= DEPTH_N;
            bypass_q     <= 1'b0;
            idx_q        <= '0;
            err_q        <= 1'b0;
            cfg_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            prod_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            bypass_q     <= bypass_d;
            idx_q        <= idx_d;
            err_q        <= err_d;
            cfg_ready_q  <= cfg_ready_d;
            busy_q       <= busy_d;
            prod_ready_q <= prod_ready_d;
        end
    end

    assign io.cfg_ready      = cfg_ready_q;
    assign io.prod_ready     = prod_ready_q;
    assign io.busy           = busy_q;
    assign io.err_addr       = err_q;
    assign io.psum_out_valid = out_valid;
    assign io.psum_in_ready  = drain & ~bypass_q & io.psum_out_ready;
    assign io.psum_out_data  = drain ? drain_sum : '0;
endmodule
